// File: rtl/decode_pipe_unit.sv
// Decode stage: register file with write-through bypass, opcode-driven immediate, RAW scoreboard.
// One-cycle latency into a registered output; in_ready drops on hazard, flush or held-output backpressure.
`timescale 1ns/1ps
module decode_pipe_unit #(
  parameter int CORE         = 0,
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int REG_SEL_BITS = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [31:0]             instruction,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    out_ready,
  output logic                    out_valid,
  input  logic                    flush,
  input  logic                    write,
  input  logic [REG_SEL_BITS-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [ADDRESS_BITS-1:0] PC_out,
  output logic [6:0]              opcode,
  output logic [2:0]              funct3,
  output logic [6:0]              funct7,
  output logic [REG_SEL_BITS-1:0] rd,
  output logic [DATA_WIDTH-1:0]   rs1_data,
  output logic [DATA_WIDTH-1:0]   rs2_data,
  output logic [DATA_WIDTH-1:0]   extend_imm,
  output logic [ADDRESS_BITS-1:0] branch_target,
  output logic [ADDRESS_BITS-1:0] JAL_target,
  input  logic                    report
);

  localparam int NREG = 1 << REG_SEL_BITS;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [ADDRESS_BITS-1:0] pc;
    logic [31:0]             instr;
    logic [DATA_WIDTH-1:0]   rs1_dat;
    logic [DATA_WIDTH-1:0]   rs2_dat;
    logic [DATA_WIDTH-1:0]   imm_dat;
  } hold_t;

  logic [DATA_WIDTH-1:0]   r_regs [NREG];
  logic [NREG-1:0]         r_busy;
  logic                    r_out_vld;
  hold_t                   r_hold;

  logic [6:0]              w_op;
  logic [REG_SEL_BITS-1:0] w_rs1, w_rs2, w_rd, w_hold_rd;
  logic                    w_use_rs1, w_use_rs2, w_wr_rd, w_hold_wr_rd;
  logic                    w_wb, w_hazard, w_accept;
  logic [DATA_WIDTH-1:0]   w_rs1_dat, w_rs2_dat, w_imm;
  logic [NREG-1:0]         w_busy_nxt;
  hold_t                   w_hold_nxt;

  function automatic logic f_writes_rd(input logic [6:0] op, input logic [REG_SEL_BITS-1:0] r);
    return (op != OP_STORE) && (op != OP_BRANCH) && (r != '0);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_imm(input logic [31:0] i);
    logic [DATA_WIDTH-1:0] v;
    v = DATA_WIDTH'($signed(i[31:20]));
    case (i[6:0])
      OP_STORE:         v = DATA_WIDTH'($signed({i[31:25], i[11:7]}));
      OP_BRANCH:        v = DATA_WIDTH'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      OP_LUI, OP_AUIPC: v = DATA_WIDTH'($signed({i[31:12], 12'b0}));
      OP_JAL:           v = DATA_WIDTH'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default:          v = DATA_WIDTH'($signed(i[31:20]));
    endcase
    return v;
  endfunction

  assign w_op         = instruction[6:0];
  assign w_rs1        = REG_SEL_BITS'(instruction[19:15]);
  assign w_rs2        = REG_SEL_BITS'(instruction[24:20]);
  assign w_rd         = REG_SEL_BITS'(instruction[11:7]);
  assign w_hold_rd    = REG_SEL_BITS'(r_hold.instr[11:7]);
  assign w_use_rs1    = (w_op != OP_LUI) && (w_op != OP_AUIPC) && (w_op != OP_JAL);
  assign w_use_rs2    = (w_op == OP_RTYPE) || (w_op == OP_STORE) || (w_op == OP_BRANCH);
  assign w_wr_rd      = f_writes_rd(w_op, w_rd);
  assign w_hold_wr_rd = f_writes_rd(r_hold.instr[6:0], w_hold_rd);
  assign w_wb         = write && (write_reg != '0);

  // x0 reads zero; a same-cycle writeback overrides the stored value
  assign w_rs1_dat = (w_rs1 == '0) ? '0 : (w_wb && write_reg == w_rs1) ? write_data : r_regs[w_rs1];
  assign w_rs2_dat = (w_rs2 == '0) ? '0 : (w_wb && write_reg == w_rs2) ? write_data : r_regs[w_rs2];
  assign w_imm     = f_imm(instruction);

  assign w_hazard = in_valid &&
                    ((w_use_rs1 && r_busy[w_rs1] && !(write && write_reg == w_rs1)) ||
                     (w_use_rs2 && r_busy[w_rs2] && !(write && write_reg == w_rs2)));
  assign in_ready = reset && (!r_out_vld || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_busy_nxt = r_busy;
    if (write) w_busy_nxt[write_reg] = 1'b0;
    if (flush && r_out_vld && w_hold_wr_rd) w_busy_nxt[w_hold_rd] = 1'b0;
    // set after clears so the newer producer keeps the register busy
    if (w_accept && w_wr_rd) w_busy_nxt[w_rd] = 1'b1;
  end

  always_comb begin
    w_hold_nxt.pc      = PC;
    w_hold_nxt.instr   = instruction;
    w_hold_nxt.rs1_dat = w_rs1_dat;
    w_hold_nxt.rs2_dat = w_rs2_dat;
    w_hold_nxt.imm_dat = w_imm;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wb) begin
      r_regs[write_reg] <= write_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy    <= '0;
      r_out_vld <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_accept) begin
        r_out_vld <= 1'b1;
        r_hold    <= w_hold_nxt;
      end else if (flush || out_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign out_valid     = r_out_vld;
  assign PC_out        = r_hold.pc;
  assign opcode        = r_hold.instr[6:0];
  assign funct3        = r_hold.instr[14:12];
  assign funct7        = r_hold.instr[31:25];
  assign rd            = w_hold_rd;
  assign rs1_data      = r_hold.rs1_dat;
  assign rs2_data      = r_hold.rs2_dat;
  assign extend_imm    = r_hold.imm_dat;
  // offsets truncated to the address width give the same result modulo 2^ADDRESS_BITS
  assign branch_target = r_hold.pc + ADDRESS_BITS'($signed({r_hold.instr[31], r_hold.instr[7],
                         r_hold.instr[30:25], r_hold.instr[11:8], 1'b0}));
  assign JAL_target    = r_hold.pc + ADDRESS_BITS'($signed({r_hold.instr[31], r_hold.instr[19:12],
                         r_hold.instr[20], r_hold.instr[30:21], 1'b0}));

`ifndef SYNTHESIS
  logic [31:0] r_cycle;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (report)
        $display("core%0d cycle=%0d pc_out=%h out_valid=%b in_ready=%b busy=%h",
                 CORE, r_cycle, PC_out, out_valid, in_ready, r_busy);
    end
  end
`endif

endmodule

// File: tb/tb_decode_pipe_unit.sv
// Bench for decode_pipe_unit: directed scenarios plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_decode_pipe_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] PC;
  logic [31:0] instruction;
  logic        in_valid, in_ready, out_ready, out_valid, flush, write, report;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [19:0] PC_out, branch_target, JAL_target;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] rs1_data, rs2_data, extend_imm;

  decode_pipe_unit #(.CORE(0), .ADDRESS_BITS(20), .DATA_WIDTH(32), .REG_SEL_BITS(5)) dut (
    .clock(clock), .reset(reset), .PC(PC), .instruction(instruction),
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .flush(flush), .write(write), .write_reg(write_reg), .write_data(write_data),
    .PC_out(PC_out), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .extend_imm(extend_imm),
    .branch_target(branch_target), .JAL_target(JAL_target), .report(report));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  logic        m_vld;
  logic [19:0] m_pc;
  logic [31:0] m_instr, m_rs1, m_rs2;
  logic        obs_rdy, exp_rdy;

  function automatic bit uses_rs1(logic [6:0] op);
    return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
  endfunction
  function automatic bit uses_rs2(logic [6:0] op);
    return op == 7'h33 || op == 7'h23 || op == 7'h63;
  endfunction
  function automatic bit writes_rd(logic [31:0] i);
    return i[6:0] != 7'h23 && i[6:0] != 7'h63 && i[11:7] != 5'd0;
  endfunction

  function automatic logic [31:0] b_imm(logic [31:0] i);
    int hi = i[31] ? -1 : 0;
    return hi * 4096 + i[7] * 2048 + i[30:25] * 32 + i[11:8] * 2;
  endfunction
  function automatic logic [31:0] j_imm(logic [31:0] i);
    int hi = i[31] ? -1 : 0;
    return hi * 1048576 + i[19:12] * 4096 + i[20] * 2048 + i[30:21] * 2;
  endfunction
  function automatic logic [31:0] exp_imm(logic [31:0] i);
    int hi = i[31] ? -1 : 0;
    case (i[6:0])
      7'h23:        return hi * 4096 + i[31:25] * 32 + i[11:7];
      7'h63:        return b_imm(i);
      7'h37, 7'h17: return i & 32'hFFFFF000;
      7'h6F:        return j_imm(i);
      default:      return hi * 4096 + i[31:20];
    endcase
  endfunction
  function automatic logic [19:0] exp_target(logic [19:0] pc, logic [31:0] off);
    logic [31:0] t = {12'd0, pc} + off;
    return t[19:0];
  endfunction

  function automatic logic m_ready();
    logic [4:0] a = instruction[19:15];
    logic [4:0] b = instruction[24:20];
    logic haz;
    haz = in_valid && ((uses_rs1(instruction[6:0]) && m_busy[a] && !(write && write_reg == a)) ||
                       (uses_rs2(instruction[6:0]) && m_busy[b] && !(write && write_reg == b)));
    return reset && (!m_vld || out_ready) && !haz && !flush;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) begin m_regs[r] = 0; m_busy[r] = 0; end
    m_vld = 0; m_pc = 0; m_instr = 0; m_rs1 = 0; m_rs2 = 0;
  endtask

  task automatic m_edge();
    logic [4:0] a = instruction[19:15];
    logic [4:0] b = instruction[24:20];
    logic [31:0] v1, v2;
    bit acc = in_valid && exp_rdy;
    v1 = (a == 0) ? 32'd0 : (write && write_reg == a) ? write_data : m_regs[a];
    v2 = (b == 0) ? 32'd0 : (write && write_reg == b) ? write_data : m_regs[b];
    if (flush && m_vld && writes_rd(m_instr)) m_busy[m_instr[11:7]] = 0;
    if (write) m_busy[write_reg] = 0;
    if (acc && writes_rd(instruction)) m_busy[instruction[11:7]] = 1;
    if (write && write_reg != 0) m_regs[write_reg] = write_data;
    if (acc) begin
      m_vld = 1; m_pc = PC; m_instr = instruction; m_rs1 = v1; m_rs2 = v2;
    end else if (flush || out_ready) m_vld = 0;
  endtask

  // one clock: sample in_ready before the edge, advance model at the edge
  task automatic tick();
    #1;
    obs_rdy = in_ready;
    exp_rdy = m_ready();
    @(posedge clock);
    m_edge();
    #1;
  endtask

  task automatic drain();
    in_valid = 0; flush = 0; out_ready = 1; write = 0;
    for (int r = 1; r < 32; r++) begin
      if (m_busy[r]) begin
        write = 1; write_reg = 5'(r); write_data = $urandom; tick();
      end
    end
    write = 0; tick();
  endtask

  task automatic test_reset();
    reset = 0; in_valid = 1; instruction = 32'h00100313; out_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (rs1_data !== 32'd0) $display("FAIL reset_rs1_data: got %h want 0", rs1_data); else n_pass++;
    n_checks++; if (extend_imm !== 32'd0) $display("FAIL reset_imm: got %h want 0", extend_imm); else n_pass++;
    in_valid = 0; reset = 1; m_reset();
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_basic();
    write = 1; write_reg = 5; write_data = 32'h1234; in_valid = 0; tick();
    write = 0; in_valid = 1; instruction = 32'h00028313; PC = 20'h100; tick();
    n_checks++; if (obs_rdy !== 1'b1) $display("FAIL basic_in_ready: got %b want 1", obs_rdy); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (rs1_data !== 32'h1234) $display("FAIL basic_rs1: got %h want 00001234", rs1_data); else n_pass++;
    n_checks++; if (extend_imm !== 32'd0) $display("FAIL basic_imm: got %h want 0", extend_imm); else n_pass++;
    n_checks++; if (rd !== 5'd6) $display("FAIL basic_rd: got %0d want 6", rd); else n_pass++;
    in_valid = 0; tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", out_valid); else n_pass++;
    drain();
  endtask

  task automatic test_write_bypass();
    in_valid = 1; instruction = 32'h00038093; PC = 20'h104;
    write = 1; write_reg = 7; write_data = 32'hAA; tick();
    n_checks++; if (obs_rdy !== 1'b1) $display("FAIL bypass_in_ready: got %b want 1", obs_rdy); else n_pass++;
    n_checks++; if (rs1_data !== 32'hAA) $display("FAIL bypass_rs1: got %h want 000000aa", rs1_data); else n_pass++;
    write = 0; PC = 20'h108; tick();
    n_checks++; if (rs1_data !== 32'hAA) $display("FAIL stored_rs1: got %h want 000000aa", rs1_data); else n_pass++;
    in_valid = 0; tick();
    drain();
  endtask

  task automatic test_raw_stall();
    in_valid = 1; out_ready = 1; instruction = 32'h00100313; PC = 20'h200; tick();
    n_checks++; if (obs_rdy !== 1'b1) $display("FAIL raw_first_ready: got %b want 1", obs_rdy); else n_pass++;
    instruction = 32'h00630433; PC = 20'h204; tick();
    n_checks++; if (obs_rdy !== 1'b0) $display("FAIL raw_stall1: got %b want 0", obs_rdy); else n_pass++;
    tick();
    n_checks++; if (obs_rdy !== 1'b0) $display("FAIL raw_stall2: got %b want 0", obs_rdy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL raw_bubble: got %b want 0", out_valid); else n_pass++;
    write = 1; write_reg = 6; write_data = 32'h55; tick();
    n_checks++; if (obs_rdy !== 1'b1) $display("FAIL raw_release: got %b want 1", obs_rdy); else n_pass++;
    n_checks++; if (rs1_data !== 32'h55 || rs2_data !== 32'h55)
      $display("FAIL raw_operands: got %h/%h want 00000055/00000055", rs1_data, rs2_data); else n_pass++;
    n_checks++; if (PC_out !== 20'h204) $display("FAIL raw_pc: got %h want 00204", PC_out); else n_pass++;
    write = 0; in_valid = 0; tick();
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1; in_valid = 1; instruction = 32'h00300513; PC = 20'h40; tick();
    out_ready = 0; instruction = 32'h00400593; PC = 20'h44;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (obs_rdy !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", k, obs_rdy); else n_pass++;
      n_checks++; if (out_valid !== 1'b1 || PC_out !== 20'h40 || extend_imm !== 32'd3 || rd !== 5'd10)
        $display("FAIL bp_hold[%0d]: got v=%b pc=%h imm=%h rd=%0d want v=1 pc=00040 imm=00000003 rd=10",
                 k, out_valid, PC_out, extend_imm, rd); else n_pass++;
    end
    out_ready = 1; tick();
    n_checks++; if (obs_rdy !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", obs_rdy); else n_pass++;
    n_checks++; if (PC_out !== 20'h44 || extend_imm !== 32'd4)
      $display("FAIL bp_next: got pc=%h imm=%h want pc=00044 imm=00000004", PC_out, extend_imm); else n_pass++;
    in_valid = 0; tick();
    drain();
  endtask

  task automatic test_immediates();
    logic [31:0] ti [5] = '{32'hfe010113, 32'hfef42623, 32'hfe000ee3, 32'h12345637, 32'hff9ff0ef};
    logic [19:0] tp [5] = '{20'h4, 20'h18, 20'h20, 20'h30, 20'h0};
    logic [31:0] te [5] = '{32'hFFFFFFE0, 32'hFFFFFFEC, 32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFF8};
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      instruction = ti[i]; PC = tp[i]; tick();
      n_checks++; if (obs_rdy !== 1'b1 || PC_out !== tp[i])
        $display("FAIL imm_accept[%0d]: got rdy=%b pc=%h want rdy=1 pc=%h", i, obs_rdy, PC_out, tp[i]); else n_pass++;
      n_checks++; if (extend_imm !== te[i])
        $display("FAIL imm_value[%0d]: got %h want %h", i, extend_imm, te[i]); else n_pass++;
      if (i == 2) begin
        n_checks++; if (branch_target !== 20'h1C) $display("FAIL branch_target: got %h want 0001c", branch_target); else n_pass++;
      end
      if (i == 4) begin
        n_checks++; if (JAL_target !== 20'hFFFF8) $display("FAIL jal_wrap: got %h want ffff8", JAL_target); else n_pass++;
      end
    end
    in_valid = 0; tick();
    drain();
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; instruction = 32'h00700493; PC = 20'h300; tick();
    flush = 1; instruction = 32'h00048713; PC = 20'h304; tick();
    n_checks++; if (obs_rdy !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", obs_rdy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else n_pass++;
    flush = 0; out_ready = 1; tick();
    n_checks++; if (obs_rdy !== 1'b1) $display("FAIL flush_busy9_cleared: got rdy=%b want 1", obs_rdy); else n_pass++;
    n_checks++; if (out_valid !== 1'b1 || PC_out !== 20'h304)
      $display("FAIL flush_next: got v=%b pc=%h want v=1 pc=00304", out_valid, PC_out); else n_pass++;
    in_valid = 0; tick();
    drain();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 0; in_valid = 1; instruction = 32'h00100313; PC = 20'h400; tick();
    instruction = 32'h00630433; PC = 20'h404; tick();
    n_checks++; if (obs_rdy !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL rst_stall_pre: got rdy=%b v=%b want rdy=0 v=1", obs_rdy, out_valid); else n_pass++;
    reset = 0; #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", out_valid); else n_pass++;
    m_reset();
    @(posedge clock); #1;
    reset = 1; out_ready = 1; tick();
    n_checks++; if (obs_rdy !== 1'b1) $display("FAIL rst_scoreboard_clear: got rdy=%b want 1", obs_rdy); else n_pass++;
    n_checks++; if (rs1_data !== 32'd0) $display("FAIL rst_regfile_clear: got %h want 0", rs1_data); else n_pass++;
    in_valid = 0; tick();
    drain();
  endtask

  task automatic test_random();
    logic [6:0] ops [9] = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    logic [177:0] got, want;
    for (int c = 0; c < 400; c++) begin
      instruction        = $urandom;
      instruction[6:0]   = ops[$urandom_range(0, 8)];
      instruction[11:7]  = 5'($urandom_range(0, 7));
      instruction[19:15] = 5'($urandom_range(0, 7));
      instruction[24:20] = 5'($urandom_range(0, 7));
      PC         = 20'($urandom);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      write      = ($urandom_range(0, 1) == 1);
      write_reg  = 5'($urandom_range(0, 7));
      write_data = $urandom;
      tick();
      n_checks++; if (obs_rdy !== exp_rdy) $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, obs_rdy, exp_rdy); else n_pass++;
      n_checks++; if (out_valid !== m_vld) $display("FAIL rnd_out_valid[%0d]: got %b want %b", c, out_valid, m_vld); else n_pass++;
      if (m_vld) begin
        got  = {PC_out, opcode, funct3, funct7, rd, rs1_data, rs2_data, extend_imm, branch_target, JAL_target};
        want = {m_pc, m_instr[6:0], m_instr[14:12], m_instr[31:25], m_instr[11:7], m_rs1, m_rs2,
                exp_imm(m_instr), exp_target(m_pc, b_imm(m_instr)), exp_target(m_pc, j_imm(m_instr))};
        n_checks++; if (got !== want) $display("FAIL rnd_fields[%0d]: got %h want %h", c, got, want); else n_pass++;
      end
    end
    drain();
  endtask

  initial begin
    reset = 0; PC = 0; instruction = 0; in_valid = 0; out_ready = 0; flush = 0;
    write = 0; write_reg = 0; write_data = 0; report = 0;
    m_reset();
    test_reset();
    test_basic();
    test_write_bypass();
    test_raw_stall();
    test_backpressure();
    test_immediates();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_pipe_unit.md
Name: decode_pipe_unit

Overview:
Parametrised, pipelined successor to the single-cycle decode unit. It contains a register file with write-through bypass, automatic immediate selection from the opcode for I/S/B/U/J formats, and a per-register scoreboard that stalls on RAW hazards. Outputs are registered behind a valid/ready handshake, so the block sits between fetch and execute in pipelined BRISC-V cores.

Parameters:
CORE, 0, core index used in report messages.
ADDRESS_BITS, 20, PC and target width.
DATA_WIDTH, 32, register and immediate width; must be at least 32.
REG_SEL_BITS, 5, register index width; the file holds 2^REG_SEL_BITS entries.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset.
PC  input  ADDRESS_BITS  PC of the incoming instruction.
instruction  input  32  incoming instruction.
in_valid  input  1  incoming instruction is valid.
in_ready  output  1  block accepts the incoming instruction this cycle.
out_ready  input  1  execute stage accepts the output register.
out_valid  output  1  output register holds a valid decoded instruction.
flush  input  1  discard the held instruction and block acceptance.
write  input  1  writeback enable.
write_reg  input  REG_SEL_BITS  writeback register index.
write_data  input  DATA_WIDTH  writeback data.
PC_out  output  ADDRESS_BITS  PC of the held instruction.
opcode  output  7  held instruction[6:0].
funct3  output  3  held instruction[14:12].
funct7  output  7  held instruction[31:25].
rd  output  REG_SEL_BITS  destination register of the held instruction.
rs1_data  output  DATA_WIDTH  operand 1 captured at acceptance.
rs2_data  output  DATA_WIDTH  operand 2 captured at acceptance.
extend_imm  output  DATA_WIDTH  sign-extended immediate of the held instruction.
branch_target  output  ADDRESS_BITS  PC_out + B-immediate, truncated to ADDRESS_BITS.
JAL_target  output  ADDRESS_BITS  PC_out + J-immediate, truncated to ADDRESS_BITS.
report  input  1  when 1, print a state dump each clock.

Behaviour:
- Reset (reset=0, asynchronous):
  - all register-file entries, scoreboard bits and output registers go to 0.
  - out_valid=0; in_ready=0 while reset is asserted.
- Register x0 always reads 0, is never written and never marked busy.
- Write port: when write=1 and write_reg!=0, register[write_reg] is updated on the rising edge.
- Read bypass: if write=1 and write_reg==rs!=0, rs data is write_data, not the stored value.
- Operand use:
  - rs1 is used by every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 is used only by R-type (0110011), STORE (0100011) and BRANCH (1100011).
- Writes-rd: every opcode except STORE and BRANCH, provided rd!=0.
- Hazard: in_valid=1, a used source has its busy bit set, and that bit is not being cleared by the writeback in the same cycle.
- Handshake: in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
  - Accept = in_valid & in_ready.
  - On accept, the output register captures PC, the instruction fields, bypassed operands and the immediate; out_valid=1 next cycle.
  - Decode latency is 1 cycle.
- If out_valid & out_ready and there is no accept, out_valid=0 next cycle.
- While out_valid=1 and out_ready=0, the held outputs stay stable.
- Scoreboard:
  - Set busy[rd] on accept of a writes-rd instruction.
  - Clear busy[write_reg] on write=1.
  - If set and clear hit the same index in the same cycle, set wins (the newer producer).
- Flush:
  - out_valid=0 next cycle.
  - If the held instruction was valid and writes-rd, its busy bit is cleared, unless a same-cycle set hits the same index.
  - No acceptance during a flush cycle.
- Immediate selected from opcode:
  - S: STORE.
  - B: BRANCH.
  - U: LUI/AUIPC, as {imm[31:12], 12'b0}.
  - J: JAL.
  - I: everything else.
  - All formats are sign-extended to DATA_WIDTH.
- Targets: branch_target and JAL_target are computed from the registered PC and instruction, wrapping modulo 2^ADDRESS_BITS.
- Report: on each clock with report=1, $display CORE, cycle count, PC_out, out_valid, in_ready and the scoreboard vector.

Test Plan:
- Reset then write x5=0x1234, then issue 0x00028313 (addi x6,x5,0): one cycle after acceptance, out_valid=1, rs1_data=0x1234, extend_imm=0.
- Write x7=0xAA in the same cycle that an instruction reading x7 is accepted: rs1_data=0xAA (bypass path).
- Issue addi x6,x0,1, then add x8,x6,x6 with no writeback: in_ready=0 for the second instruction. Assert write x6 with the stall still pending: the second instruction is accepted that cycle.
- Hold out_ready=0 with in_valid=1: out_valid stays 1, outputs stay stable, in_ready=0. Release out_ready: next instruction accepted in that cycle.
- Issue 0xfe010113 at PC=4 and 0xfef42623 at PC=0x18: extend_imm is 0xFFFFFFE0 and 0xFFFFFFEC. Issue a branch 0xfe000ee3 at PC=0x20: branch_target=0x1C.
- Flush while holding addi x9: out_valid=0 next cycle, busy[9]=0. Assert reset mid-stall: scoreboard is cleared and out_valid=0 immediately.
